// File: rtl/memory_pkg.sv
// Shared memory-system constants used to size fetch address ports.
package memory_pkg;
    localparam int MEM_ADDR_WIDTH = 32;
endpackage

// File: rtl/core_run_controller.sv
// Boot/run/drain/halt sequencer for a core under test.
// Define RUN_CTRL_WATCHDOG_EN to build the RUN-state watchdog and its TIMEOUT path.
module core_run_controller #(
    parameter int                ADDR_W           = memory_pkg::MEM_ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] FIRST_FETCH_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR         = 'h20,
    parameter int                DRAIN_CYCLES     = 4,
    parameter int                WATCHDOG_TIM     = 200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              first_fetch_trigger,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_request,
    input  logic              wdog_kick,
    input  logic              status_clear,
    output logic              core_clk_en,
    output logic              fetch_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       run_cycles
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BOOT    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] HALT    = 3'd4;
    localparam logic [2:0] TIMEOUT = 3'd5;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       trig_q;
    logic       trig_armed;
    logic       trig_rise;
    logic       end_hit;
    logic       wd_expire;
    logic [3:0] drain_cnt;

    // trig_armed stays low for the first edge after reset so a trigger held
    // high through reset release is not mistaken for a fresh edge.
    assign trig_rise = trig_armed && first_fetch_trigger && !trig_q;
    assign end_hit   = inst_request && (inst_addr == END_ADDR);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trig_rise) next_state = BOOT;
            BOOT:    next_state = RUN;
            RUN: begin
                if (end_hit)        next_state = DRAIN;
                else if (wd_expire) next_state = TIMEOUT;
            end
            DRAIN:   if (drain_cnt == 4'd1) next_state = HALT;
            HALT,
            TIMEOUT: if (status_clear) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            trig_q       <= 1'b0;
            trig_armed   <= 1'b0;
            drain_cnt    <= '0;
            core_clk_en  <= 1'b0;
            fetch_en     <= 1'b0;
            pc_load      <= 1'b0;
            pc_load_addr <= '0;
            done         <= 1'b0;
            run_cycles   <= '0;
        end else begin
            state       <= next_state;
            trig_q      <= first_fetch_trigger;
            trig_armed  <= 1'b1;
            core_clk_en <= (next_state == BOOT) || (next_state == RUN) || (next_state == DRAIN);
            fetch_en    <= (next_state == RUN);
            pc_load     <= (next_state == BOOT);
            done        <= (next_state == HALT);
            if (next_state == BOOT)
                pc_load_addr <= FIRST_FETCH_ADDR;
            if (state != DRAIN)
                drain_cnt <= 4'(DRAIN_CYCLES);
            else
                drain_cnt <= drain_cnt - 4'd1;
            if (next_state == IDLE)
                run_cycles <= '0;
            else if (state == RUN && run_cycles != '1)
                run_cycles <= run_cycles + 32'd1;
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt;

    // A kick in the expiry cycle clears the counter instead of expiring.
    assign wd_expire = !wdog_kick && (wd_cnt == 32'(WATCHDOG_TIM - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= (next_state == TIMEOUT);
            if (state != RUN && next_state == RUN)
                wd_cnt <= '0;
            else if (state == RUN) begin
                if (wdog_kick)
                    wd_cnt <= '0;
                else
                    wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end
`else
    localparam int unused_wdog_tim = WATCHDOG_TIM;
    logic unused_wdog_kick;

    assign unused_wdog_kick = wdog_kick;
    assign wd_expire        = 1'b0;
    assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller: expected outputs queued per cycle and checked after each edge.
module tb_core_run_controller;

    localparam int ADDR_W = 32;

    // {core_clk_en, fetch_en, pc_load, done, timeout}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_BOOT  = 5'b10100;
    localparam logic [4:0] F_RUN   = 5'b11000;
    localparam logic [4:0] F_DRAIN = 5'b10000;
    localparam logic [4:0] F_HALT  = 5'b00010;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [4:0] F_TMO   = 5'b00001;
`endif

    logic              clk;
    logic              rstn;
    logic              first_fetch_trigger;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_request;
    logic              wdog_kick;
    logic              status_clear;
    logic              core_clk_en;
    logic              fetch_en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              done;
    logic              timeout;
    logic [31:0]       run_cycles;

    core_run_controller dut (
        .clk                 (clk),
        .rstn                (rstn),
        .first_fetch_trigger (first_fetch_trigger),
        .inst_addr           (inst_addr),
        .inst_request        (inst_request),
        .wdog_kick           (wdog_kick),
        .status_clear        (status_clear),
        .core_clk_en         (core_clk_en),
        .fetch_en            (fetch_en),
        .pc_load             (pc_load),
        .pc_load_addr        (pc_load_addr),
        .done                (done),
        .timeout             (timeout),
        .run_cycles          (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  flags;
        logic [31:0] rc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned rc_model = 0;

    function automatic logic [4:0] obs_flags();
        return {core_clk_en, fetch_en, pc_load, done, timeout};
    endfunction

    task automatic push_exp(input string tag, input logic [4:0] f, input logic [31:0] rc);
        exp_t e;
        e.tag   = tag;
        e.flags = f;
        e.rc    = rc;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [4:0]  of;
        e  = sb.pop_front();
        of = obs_flags();
        tests++;
        assert (of === e.flags) else begin
            fails++;
            $error("FAIL %s flags: observed %b expected %b", e.tag, of, e.flags);
        end
        tests++;
        assert (run_cycles === e.rc) else begin
            fails++;
            $error("FAIL %s run_cycles: observed %0d expected %0d", e.tag, run_cycles, e.rc);
        end
        tests++;
        assert (pc_load_addr === {ADDR_W{1'b0}}) else begin
            fails++;
            $error("FAIL %s pc_load_addr: observed %h expected 0", e.tag, pc_load_addr);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] f, input logic [31:0] rc);
        push_exp(tag, f, rc);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic start_run();
        first_fetch_trigger = 1'b0;
        step("pre_idle", F_IDLE, 32'd0);
        first_fetch_trigger = 1'b1;
        step("boot", F_BOOT, 32'd0);
        step("run_entry", F_RUN, 32'd0);
        rc_model = 0;
    endtask

    task automatic run_for(input int n, input int kick_every, input bit end_last);
        for (int k = 0; k < n; k++) begin
            wdog_kick    = (kick_every > 0) && ((rc_model % kick_every) == kick_every - 1);
            inst_request = end_last && (k == n - 1);
            inst_addr    = inst_request ? ADDR_W'('h20) : ADDR_W'('h1c);
            step(inst_request ? "end_fetch" : "run", inst_request ? F_DRAIN : F_RUN, rc_model + 1);
            rc_model++;
        end
        wdog_kick    = 1'b0;
        inst_request = 1'b0;
    endtask

    task automatic drain_halt();
        for (int k = 0; k < 3; k++)
            step("drain", F_DRAIN, rc_model);
        step("halt", F_HALT, rc_model);
    endtask

    task automatic clear_status();
        status_clear = 1'b1;
        step("clear", F_IDLE, 32'd0);
        status_clear = 1'b0;
        rc_model = 0;
    endtask

    initial begin
        rstn                = 1'b1;
        first_fetch_trigger = 1'b0;
        inst_addr           = '0;
        inst_request        = 1'b0;
        wdog_kick           = 1'b0;
        status_clear        = 1'b0;

        #3 rstn = 1'b0;
        #1;
        push_exp("reset", F_IDLE, 32'd0);
        check_pop();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++)
            step("idle", F_IDLE, 32'd0);

        // First run: near-miss fetches and status_clear must not end RUN.
        start_run();
        inst_request = 1'b1;
        inst_addr    = 'h21;
        step("near_addr", F_RUN, 32'd1);
        inst_addr    = 'h8000_0020;
        step("high_bits", F_RUN, 32'd2);
        inst_request = 1'b0;
        inst_addr    = 'h20;
        status_clear = 1'b1;
        step("no_request", F_RUN, 32'd3);
        status_clear = 1'b0;
        inst_request = 1'b1;
        step("end_fetch", F_DRAIN, 32'd4);
        inst_request = 1'b0;
        rc_model     = 4;
        drain_halt();

        first_fetch_trigger = 1'b0;
        step("halt_hold", F_HALT, 32'd4);
        first_fetch_trigger = 1'b1;
        step("halt_trig", F_HALT, 32'd4);
        step("halt_trig2", F_HALT, 32'd4);
        clear_status();
        step("idle_held_trig", F_IDLE, 32'd0);

        // End-of-test in the 200th RUN cycle wins over a same-cycle expiry.
        start_run();
        run_for(200, 0, 1'b1);
        drain_halt();
        clear_status();

`ifdef RUN_CTRL_WATCHDOG_EN
        start_run();
        run_for(199, 0, 1'b0);
        step("timeout", F_TMO, 32'd200);
        first_fetch_trigger = 1'b0;
        step("timeout_hold", F_TMO, 32'd200);
        clear_status();

        start_run();
        run_for(350, 100, 1'b0);
        run_for(1, 0, 1'b1);
        drain_halt();
        clear_status();
`else
        start_run();
        run_for(250, 50, 1'b0);
        run_for(1, 0, 1'b1);
        drain_halt();
        clear_status();
`endif

        // Reset mid-DRAIN with the trigger held high across release.
        start_run();
        run_for(2, 0, 1'b1);
        step("drain_pre_rst", F_DRAIN, 32'd2);
        #2 rstn = 1'b0;
        #1;
        push_exp("rst_mid_drain", F_IDLE, 32'd0);
        check_pop();
        #3 rstn = 1'b1;
        for (int i = 0; i < 3; i++)
            step("held_trig_no_run", F_IDLE, 32'd0);
        first_fetch_trigger = 1'b0;
        step("trig_low", F_IDLE, 32'd0);
        first_fetch_trigger = 1'b1;
        step("boot_after_rst", F_BOOT, 32'd0);
        step("run_after_rst", F_RUN, 32'd0);
        rc_model = 0;
        run_for(1, 0, 1'b1);
        drain_halt();
        clear_status();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 Parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, fetch address width.
REQ-002 Parameter FIRST_FETCH_ADDR, default 0, PC value loaded at boot.
REQ-003 Parameter END_ADDR, default 'h20, fetch address that marks end of test.
REQ-004 Parameter DRAIN_CYCLES, default 4, pipeline drain cycles after end of test (range 1..15).
REQ-005 Parameter WATCHDOG_TIM, default 200, watchdog expiry in cycles.
REQ-006 clk  input  1  single clock.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 first_fetch_trigger  input  1  start request from bench or host.
REQ-009 inst_addr  input  ADDR_W  core fetch address.
REQ-010 inst_request  input  1  core fetch valid.
REQ-011 wdog_kick  input  1  watchdog clear, one-cycle pulse.
REQ-012 status_clear  input  1  return from HALT or TIMEOUT to IDLE.
REQ-013 core_clk_en  output  1  enable for the core ClockGate.
REQ-014 fetch_en  output  1  permits the core to issue fetches.
REQ-015 pc_load / pc_load_addr  output  1 / ADDR_W  one-cycle PC load strobe and value.
REQ-016 done / timeout  output  1 / 1  sticky completion and watchdog-expiry flags.
REQ-017 run_cycles  output  32  saturating count of cycles spent in RUN.

Function
REQ-018 States: IDLE, BOOT, RUN, DRAIN, HALT, TIMEOUT. All outputs are registered.
REQ-019 IDLE: all outputs 0. A rising edge of first_fetch_trigger (0 in the previous cycle, 1 now) moves to BOOT. A trigger held high starts exactly one run.
REQ-020 BOOT lasts exactly one cycle: pc_load=1, pc_load_addr=FIRST_FETCH_ADDR, core_clk_en=1. Next state is RUN.
REQ-021 RUN: core_clk_en=1, fetch_en=1, run_cycles increments each cycle and saturates at 32'hFFFF_FFFF.
REQ-022 In RUN, inst_request=1 with inst_addr==END_ADDR moves to DRAIN on the next edge. The comparison is full ADDR_W, with no masking.
REQ-023 DRAIN: fetch_en=0, core_clk_en=1, drain counter loaded with DRAIN_CYCLES. After DRAIN_CYCLES cycles the state moves to HALT.
REQ-024 HALT: core_clk_en=0, fetch_en=0, done=1. The state is held until status_clear.
REQ-025 TIMEOUT: core_clk_en=0, fetch_en=0, timeout=1. The state is held until status_clear.
REQ-026 status_clear in HALT or TIMEOUT returns to IDLE. This clears done, timeout and run_cycles. status_clear is ignored in all other states.
REQ-027 first_fetch_trigger is ignored outside IDLE. Its edge detector still tracks the input in every state.
REQ-028 If end-of-test detection and watchdog expiry occur in the same RUN cycle, end of test wins and the next state is DRAIN.
REQ-029 pc_load_addr holds its last value when pc_load=0.

Reset
REQ-030 rstn low asynchronously forces IDLE, zeroes all outputs, counters and the edge-detect register, in any state including mid-RUN and mid-DRAIN.
REQ-031 After rstn deasserts, a trigger edge is required to start a run. A trigger held high through reset is not treated as an edge.

Configuration
REQ-032 Macro RUN_CTRL_WATCHDOG_EN enables the watchdog.
REQ-033 With RUN_CTRL_WATCHDOG_EN defined:
- The counter is cleared on entry to RUN and on wdog_kick.
- The counter increments each RUN cycle.
- When the counter reaches WATCHDOG_TIM-1, the next state is TIMEOUT.
- The counter is frozen outside RUN.
REQ-034 Without RUN_CTRL_WATCHDOG_EN:
- No watchdog logic is present.
- timeout is tied to 0 and TIMEOUT is unreachable.
- wdog_kick is ignored.

Verification
REQ-035 Reset, trigger pulse at cycle 10 -> pc_load=1 with addr 0 at cycle 11; fetch_en=1 from cycle 12.
REQ-036 RUN with inst_request=1, inst_addr='h20 -> fetch_en=0 next cycle; done=1 and core_clk_en=0 exactly 4 cycles later.
REQ-037 Watchdog enabled, no kick, END_ADDR never fetched -> timeout=1 and core_clk_en=0 after 200 RUN cycles. A kick every 100 cycles means timeout never occurs.
REQ-038 END_ADDR fetch in the same cycle as watchdog expiry -> DRAIN, then done=1 and timeout=0.
REQ-039 rstn asserted mid-DRAIN -> all outputs 0 immediately. A trigger held high across reset release does not start a run.
REQ-040 In HALT, a second trigger is ignored. status_clear then returns to IDLE with done=0 and run_cycles=0.
